// File: rtl/seven_seg_scan.sv
// seven_seg_scan: double-buffered, blanked, time-multiplexed common-anode 7-segment driver.
// Define LEADING_ZERO_BLANK_EN to darken leading-zero digits above digit 0.
module seven_seg_scan #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic                    CA,
    output logic                    CB,
    output logic                    CC,
    output logic                    CD,
    output logic                    CE,
    output logic                    CF,
    output logic                    CG,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    frame_tick
);
    localparam int DIGIT_CYCLES = CLK_FREQ / REFRESH_HZ;
    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);
    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] DRIVE = 1'b1;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'h3F;
            4'h1: seg_of = 7'h06;
            4'h2: seg_of = 7'h5B;
            4'h3: seg_of = 7'h4F;
            4'h4: seg_of = 7'h66;
            4'h5: seg_of = 7'h6D;
            4'h6: seg_of = 7'h7D;
            4'h7: seg_of = 7'h07;
            4'h8: seg_of = 7'h7F;
            4'h9: seg_of = 7'h6F;
            4'hA: seg_of = 7'h77;
            4'hB: seg_of = 7'h7C;
            4'hC: seg_of = 7'h39;
            4'hD: seg_of = 7'h5E;
            4'hE: seg_of = 7'h79;
            default: seg_of = 7'h71;
        endcase
    endfunction

    logic [0:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   dpb_q, dpb_d, pdp_q, pdp_d;
    logic                    pend_full_q, pend_full_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick_q, tick_d;
    logic [NUM_DIGITS-1:0]   lz;
    logic                    slot_end, wrap, accept, lit;
    logic [3:0]              nib;

`ifdef LEADING_ZERO_BLANK_EN
    logic hi_zero;
    // A digit is dark when it and every digit above it hold zero; digit 0 never is.
    always_comb begin
        hi_zero = 1'b1;
        lz = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            hi_zero = hi_zero & (disp_q[4*i +: 4] == 4'h0);
            lz[i] = hi_zero;
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        slot_end    = state_q == DRIVE && cnt_q == DIGIT_LAST;
        wrap        = slot_end && idx_q == IDX_LAST;
        accept      = value_valid && !pend_full_q;
        state_d     = state_q == BLANK ? (cnt_q == BLANK_LAST ? DRIVE : BLANK) : (slot_end ? BLANK : DRIVE);
        cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
        idx_d       = slot_end ? (idx_q == IDX_LAST ? '0 : idx_q + 1'b1) : idx_q;
        pend_d      = accept ? value : pend_q;
        pdp_d       = accept ? dp_mask : pdp_q;
        pend_full_d = accept || (pend_full_q && !wrap);
        disp_d      = wrap && pend_full_q ? pend_q : disp_q;
        dpb_d       = wrap && pend_full_q ? pdp_q : dpb_q;
        nib         = disp_q[{idx_q, 2'b00} +: 4];
        lit         = state_q == DRIVE && !lz[idx_q];
        an_d        = lit ? ~(ONE << idx_q) : '1;
        seg_d       = lit ? ~seg_of(nib) : '1;
        dp_d        = lit ? ~dpb_q[idx_q] : 1'b1;
        tick_d      = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            disp_q      <= '0;
            dpb_q       <= '0;
            pend_q      <= '0;
            pdp_q       <= '0;
            pend_full_q <= 1'b0;
            seg_q       <= '1;
            dp_q        <= 1'b1;
            an_q        <= '1;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            dpb_q       <= dpb_d;
            pend_q      <= pend_d;
            pdp_q       <= pdp_d;
            pend_full_q <= pend_full_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            tick_q      <= tick_d;
        end
    end

    assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;
    assign DP          = dp_q;
    assign AN          = an_q;
    assign frame_tick  = tick_q;
    assign value_ready = ~pend_full_q;
endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed driver for a NUM_DIGITS-digit common-anode 7-segment display. It accepts a packed hex value plus decimal-point mask over a valid/ready handshake and double-buffers it, so updates only take effect at frame boundaries. It scans one digit at a time with an inter-digit blanking gap to suppress ghosting. It sits downstream of the hex counter/decoder stage and directly drives the board's segment and anode pins.

## Interface
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- REFRESH_HZ, 1000: per-digit slot rate.
  - DIGIT_CYCLES = CLK_FREQ/REFRESH_HZ (integer division).
- NUM_DIGITS, 8: digits scanned, 1..8.
- BLANK_CYCLES, 100: all-anodes-off cycles at the start of each slot.
  - Must satisfy 1 ≤ BLANK_CYCLES < DIGIT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  hex nibbles; digit 0 is bits [3:0] (rightmost).
- dp_mask  in  NUM_DIGITS  bit i lights the DP of digit i.
- value_valid  in  1  the value/dp_mask offer is valid.
- value_ready  out  1  pending buffer is empty.
- CA, CB, CC, CD, CE, CF, CG  out  1 each  active-low segments a..g.
- DP  out  1  active-low decimal point.
- AN  out  NUM_DIGITS  active-low anode enables.
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Reset values:
  - State = BLANK, digit index = 0, slot counter = 0.
  - Display buffer = 0, dp buffer = 0, pending buffer empty.
  - value_ready = 1, frame_tick = 0.
  - CA..CG, DP and all AN bits = 1 (dark).
- FSM states:
  - BLANK: AN all 1, segments all 1. Leave to DRIVE when the counter reaches BLANK_CYCLES-1.
  - DRIVE: AN[index] = 0, segments = decode(nibble[index]), DP = ~dp_buf[index]. At counter DIGIT_CYCLES-1: counter → 0, index advances, state → BLANK.
- Index wraps NUM_DIGITS-1 → 0. On the wrap edge:
  - frame_tick pulses.
  - If pending is full, pending copies into the display/dp buffers and pending is cleared.
- Handshake:
  - A transfer occurs on a clock edge with value_valid && value_ready.
  - value and dp_mask are captured into pending; value_ready goes 0 the next cycle.
  - value_ready returns to 1 the cycle after the frame swap.
  - value_valid with value_ready = 0 is ignored; the producer must hold the offer.
  - A transfer on the wrap edge itself (pending was empty) is not swapped until the following frame.
- Decoder, gfedcba active-high before inversion:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Reset asserted mid-scan or mid-handshake returns every register to its reset value on that edge. Pending data is discarded.

## Timing
- All outputs are registered and change one cycle after the FSM state/counter that selects them.
- Slot length is exactly DIGIT_CYCLES clocks; the first BLANK_CYCLES of each slot are dark.
- Frame length is NUM_DIGITS*DIGIT_CYCLES clocks.
- Accept-to-display latency is at most one frame plus the 1-cycle output register.
- The first frame_tick occurs NUM_DIGITS*DIGIT_CYCLES cycles after rst deasserts.
- At most one AN bit is low in any cycle.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Any digit i > 0 whose nibble and all higher nibbles in the display buffer are 0 is treated as BLANK for its whole slot (AN high, segments and DP high).
  - Digit 0 is always driven.
  - Slot timing and frame_tick are unchanged.
- LEADING_ZERO_BLANK_EN undefined: every digit is driven, including leading zeros.

## Test plan
Parameters for all scenarios: CLK_FREQ=1000, REFRESH_HZ=100, NUM_DIGITS=4, BLANK_CYCLES=2, so DIGIT_CYCLES=10.
- Reset scan:
  - Stimulus: hold rst 3 cycles, release.
  - Required: AN=1111 and segments=1111111 until the first DRIVE.
  - Required: AN sequence 1110, 1101, 1011, 0111, each low for 8 cycles after 2 dark cycles.
  - Required: frame_tick every 40 cycles.
- Decode:
  - Stimulus: load value=16'h1A2F, dp_mask=4'b0100.
  - Required in the next frame: digit0 {CG..CA}=~71, digit1 ~5B, digit2 ~77 with DP=0, digit3 ~06.
- Handshake backpressure:
  - Stimulus: offer 16'h1111 and then 16'h2222 back-to-back with valid held high.
  - Required: value_ready low after the first accept.
  - Required: the second word is accepted only the cycle after the next frame_tick.
  - Required: 1111 is displayed for one full frame before 2222.
- No tearing:
  - Stimulus: accept 16'hFFFF while digit 2 of value 16'h0000 is driven.
  - Required: digits 2 and 3 still show 0 for the rest of that frame; all digits show F from the next frame.
- Mid-operation reset:
  - Stimulus: assert rst during DRIVE of digit 1 with pending full.
  - Required on the next edge: all outputs are dark and value_ready=1.
  - Required: the display buffer returns to 0 and the pending data is never displayed.
- Leading-zero blanking, built with LEADING_ZERO_BLANK_EN:
  - Stimulus: value=16'h0030.
  - Required: digits 3 and 2 stay dark for their full slots, digit 1 shows 3, digit 0 shows 0.
  - Stimulus: value=16'h0000.
  - Required: only digit 0 is lit.
